// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game controller: state/phase
// codes, quadrant codes, renderer colours and LFSR constants.
package simon_pkg;

    // State encoding doubles as the phase code shown on the HUD.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXTEND   = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_OFF = 3'd3,
        ST_INPUT    = 3'd4,
        ST_ECHO     = 3'd5,
        ST_LOSE     = 3'd6,
        ST_WIN      = 3'd7
    } state_e;

    // Quadrant codes as carried on btn_code / lit_code.
    typedef enum logic [1:0] {
        Q_RED    = 2'd0,
        Q_GREEN  = 2'd1,
        Q_BLUE   = 2'd2,
        Q_YELLOW = 2'd3
    } quad_e;

    // 12-bit RGB colours used by the block renderer for each quadrant.
    localparam logic [11:0] RGB_RED    = 12'hF00;
    localparam logic [11:0] RGB_GREEN  = 12'h0F0;
    localparam logic [11:0] RGB_BLUE   = 12'h00F;
    localparam logic [11:0] RGB_YELLOW = 12'hFF0;

    // Width of the level output; holds 0..16.
    localparam int LEVEL_W = 5;

    // 16-bit Galois LFSR, right-shifting, taps 16,14,13,11.
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Maps a quadrant code to its renderer colour.
    function automatic logic [11:0] quad_rgb(input logic [1:0] code);
        logic [11:0] rgb;
        case (code)
            Q_RED:    rgb = RGB_RED;
            Q_GREEN:  rgb = RGB_GREEN;
            Q_BLUE:   rgb = RGB_BLUE;
            default:  rgb = RGB_YELLOW;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/simon_sequencer_if.sv
// Bus between the button/frame front end (master) and the Simon game
// sequencer (slave), including the renderer/HUD outputs.
interface simon_sequencer_if;
    import simon_pkg::*;

    logic               frame_tick;
    logic               start;
    logic               btn_valid;
    logic [1:0]         btn_code;
    logic               lit_valid;
    logic [1:0]         lit_code;
    logic [2:0]         phase;
    logic [LEVEL_W-1:0] level;
    logic               game_over;
    logic               win;

    modport master (
        output frame_tick, start, btn_valid, btn_code,
        input  lit_valid, lit_code, phase, level, game_over, win
    );

    modport slave (
        input  frame_tick, start, btn_valid, btn_code,
        output lit_valid, lit_code, phase, level, game_over, win
    );
endinterface

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Galois LFSR. Because it advances every clock, the
// moment the player presses start effectively seeds the colour sequence.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next-state network: shift right, feed bit 0 back into the tap positions.
    for (genvar gi = 0; gi < LFSR_W; gi++) begin : g_bit
        if (gi == LFSR_W - 1) begin : g_top
            assign lfsr_d[gi] = lfsr_q[0];
        end else if (LFSR_TAPS[gi]) begin : g_tap
            assign lfsr_d[gi] = lfsr_q[gi + 1] ^ lfsr_q[0];
        end else begin : g_shift
            assign lfsr_d[gi] = lfsr_q[gi + 1];
        end
    end

    // State register: seeded on reset, advancing every cycle otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/simon_sequencer.sv
// Simon game-flow controller: extends a random colour sequence, plays it
// back frame-timed, then checks the player's presses against it.
// Optional build macro: INPUT_TIMEOUT_EN adds a frame-counted timeout in
// the INPUT state that ends the game when the player stops pressing.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int          MAX_LEN        = 16,
    parameter int          TICK_ON        = 30,
    parameter int          TICK_OFF       = 10,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          TIMEOUT_FRAMES = 300
) (
    input  logic              clk,
    input  logic              rst,
    simon_sequencer_if.slave  bus_if
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
`ifdef INPUT_TIMEOUT_EN
    localparam int TMR_MAX = (TICK_ON > TICK_OFF)
                           ? ((TICK_ON > TIMEOUT_FRAMES) ? TICK_ON : TIMEOUT_FRAMES)
                           : ((TICK_OFF > TIMEOUT_FRAMES) ? TICK_OFF : TIMEOUT_FRAMES);
`else
    localparam int TMR_MAX = (TICK_ON > TICK_OFF) ? TICK_ON : TICK_OFF;
`endif
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]   ON_LAST  = TMR_W'(TICK_ON - 1);
    localparam logic [TMR_W-1:0]   OFF_LAST = TMR_W'(TICK_OFF - 1);
`ifdef INPUT_TIMEOUT_EN
    localparam logic [TMR_W-1:0]   TO_LAST  = TMR_W'(TIMEOUT_FRAMES - 1);
`endif
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEN);

    // Catch nonsensical configurations at elaboration time.
    if (MAX_LEN < 1 || MAX_LEN > 16 || TICK_ON < 1 || TICK_OFF < 1 ||
        TIMEOUT_FRAMES < 1 || LFSR_SEED == 16'h0000) begin : g_bad_params
        $error("simon_sequencer: invalid parameter set");
    end

    state_e             state_q;
    logic [LEVEL_W-1:0] level_q;
    logic [IDX_W-1:0]   index_q;
    logic [TMR_W-1:0]   timer_q;
    logic [1:0]         mem_q [MAX_LEN];

    logic [LFSR_W-1:0]  lfsr_state;
    logic               unused_lfsr_bits;

    logic [1:0]         cur_code;
    logic               last_step;
    logic               on_done;
    logic               off_done;

    simon_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr_state)
    );

    // Only the two low LFSR bits pick colours; the rest just spread entropy.
    assign unused_lfsr_bits = ^lfsr_state[LFSR_W-1:2];

    // Step/timer decode shared by the playback and echo states.
    always_comb begin
        cur_code  = mem_q[index_q];
        last_step = (LEVEL_W'(index_q) == level_q - 1'b1);
        on_done   = bus_if.frame_tick && (timer_q == ON_LAST);
        off_done  = bus_if.frame_tick && (timer_q == OFF_LAST);
    end

    // Sequence memory: appended to once per round, never cleared.
    always_ff @(posedge clk) begin
        if (state_q == ST_EXTEND) begin
            mem_q[level_q[IDX_W-1:0]] <= lfsr_state[1:0];
        end
    end

    // Game FSM with its frame timer; every state change clears the timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            index_q <= '0;
            timer_q <= '0;
        end else begin
            if (bus_if.frame_tick) begin
                timer_q <= timer_q + 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_LOSE, ST_WIN: begin
                    timer_q <= '0;
                    if (bus_if.start) begin
                        level_q <= '0;
                        index_q <= '0;
                        state_q <= ST_EXTEND;
                    end
                end
                ST_EXTEND: begin
                    level_q <= level_q + 1'b1;
                    index_q <= '0;
                    timer_q <= '0;
                    state_q <= ST_SHOW_ON;
                end
                ST_SHOW_ON: begin
                    if (on_done) begin
                        timer_q <= '0;
                        state_q <= ST_SHOW_OFF;
                    end
                end
                ST_SHOW_OFF: begin
                    if (off_done) begin
                        timer_q <= '0;
                        if (last_step) begin
                            index_q <= '0;
                            state_q <= ST_INPUT;
                        end else begin
                            index_q <= index_q + 1'b1;
                            state_q <= ST_SHOW_ON;
                        end
                    end
                end
                ST_INPUT: begin
`ifndef INPUT_TIMEOUT_EN
                    // Waiting indefinitely: the timer is parked at zero.
                    timer_q <= '0;
`endif
                    if (bus_if.btn_valid) begin
                        timer_q <= '0;
                        state_q <= (bus_if.btn_code == cur_code) ? ST_ECHO : ST_LOSE;
                    end
`ifdef INPUT_TIMEOUT_EN
                    else if (bus_if.frame_tick && (timer_q == TO_LAST)) begin
                        timer_q <= '0;
                        state_q <= ST_LOSE;
                    end
`endif
                end
                ST_ECHO: begin
                    if (off_done) begin
                        timer_q <= '0;
                        if (last_step) begin
                            state_q <= (level_q == LEVEL_MAX) ? ST_WIN : ST_EXTEND;
                        end else begin
                            index_q <= index_q + 1'b1;
                            state_q <= ST_INPUT;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from registered state, index and memory.
    always_comb begin
        bus_if.lit_valid = (state_q == ST_SHOW_ON) || (state_q == ST_ECHO);
        bus_if.lit_code  = bus_if.lit_valid ? cur_code : 2'd0;
        bus_if.phase     = state_q;
        bus_if.level     = level_q;
        bus_if.game_over = (state_q == ST_LOSE);
        bus_if.win       = (state_q == ST_WIN);
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer: reference LFSR model predicts
// the colours, a queue holds expected lit codes, a table drives game rounds.
`timescale 1ns/1ps
module tb_simon_sequencer;
    import simon_pkg::*;

    localparam int          MAX_LEN  = 3;
    localparam int          TICK_ON  = 2;
    localparam int          TICK_OFF = 1;
    localparam int          TO_FR    = 5;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    simon_sequencer_if bus ();

    simon_sequencer #(
        .MAX_LEN        (MAX_LEN),
        .TICK_ON        (TICK_ON),
        .TICK_OFF       (TICK_OFF),
        .LFSR_SEED      (SEED),
        .TIMEOUT_FRAMES (TO_FR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference LFSR: taps at bit positions 16,14,13,11, shifting toward bit 0.
    logic [15:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= SEED;
        else begin
            lfsr_m[15] <= lfsr_m[0];
            lfsr_m[14] <= lfsr_m[15];
            lfsr_m[13] <= lfsr_m[14] ^ lfsr_m[0];
            lfsr_m[12] <= lfsr_m[13] ^ lfsr_m[0];
            lfsr_m[11] <= lfsr_m[12];
            lfsr_m[10] <= lfsr_m[11] ^ lfsr_m[0];
            lfsr_m[9:0] <= lfsr_m[10:1];
        end
    end

    logic [1:0] exp_q [$];
    logic [1:0] mem_m [MAX_LEN];
    int         lvl_m = 0;
    logic       prev_lit = 1'b0;
    logic [2:0] prev_phase = 3'd0;

    typedef struct {
        int         lvl;
        int         wrong_at;
        bit         poke;
        logic [2:0] end_phase;
        logic [4:0] end_level;
        logic       end_go;
        logic       end_win;
    } rec_t;
    rec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard bookkeeping done once per sampled cycle.
    task automatic observe();
        if (bus.phase == 3'd1) begin
            if (prev_phase == 3'd0 || prev_phase == 3'd6 || prev_phase == 3'd7) lvl_m = 0;
            if (lvl_m < MAX_LEN) begin
                mem_m[lvl_m] = lfsr_m[1:0];
                lvl_m++;
                for (int i = 0; i < lvl_m; i++) exp_q.push_back(mem_m[i]);
            end
        end
        if (bus.lit_valid === 1'b1 && prev_lit !== 1'b1) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else check("lit_code", 32'(bus.lit_code), 32'(exp_q.pop_front()));
        end
        prev_lit   = bus.lit_valid;
        prev_phase = bus.phase;
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick_clk();
        @(posedge clk);
        #1;
        cyc++;
        bus.start      = 1'b0;
        bus.btn_valid  = 1'b0;
        bus.frame_tick = (cyc % 4 == 0);
        observe();
    endtask

    task automatic wait_phase(input logic [2:0] p, input int budget, input string name);
        int n = 0;
        while (bus.phase !== p && n < budget) begin
            tick_clk();
            n++;
        end
        check(name, 32'(bus.phase), 32'(p));
    endtask

    task automatic press(input logic [1:0] code);
        bus.btn_valid = 1'b1;
        bus.btn_code  = code;
        tick_clk();
    endtask

    task automatic play_level(input rec_t r);
        int  n     = 0;
        bit  poked = 0;
        bit  wrong = 0;
        while (bus.phase !== 3'd4 && n < 300) begin
            if (r.poke && !poked && bus.phase == 3'd2) begin
                bus.start     = 1'b1;
                bus.btn_valid = 1'b1;
                bus.btn_code  = 2'd0;
                poked = 1;
                tick_clk();
                check("poke_ignored", 32'(bus.phase == 3'd2 || bus.phase == 3'd3), 32'd1);
            end else begin
                tick_clk();
            end
            n++;
        end
        check("reach_input", 32'(bus.phase), 32'd4);
        check("level_in_input", 32'(bus.level), 32'(r.lvl));
        for (int i = 0; i < r.lvl; i++) begin
            if (i == r.wrong_at) begin
                press(mem_m[i] ^ 2'd1);
                wrong = 1;
                break;
            end
            exp_q.push_back(mem_m[i]);
            press(mem_m[i]);
            check("echo_phase", 32'(bus.phase), 32'd5);
            if (i < r.lvl - 1) wait_phase(3'd4, 20, "back_to_input");
        end
        if (!wrong) begin
            n = 0;
            while (bus.phase === 3'd5 && n < 20) begin
                tick_clk();
                n++;
            end
        end
        check("end_phase", 32'(bus.phase), 32'(r.end_phase));
        check("end_level", 32'(bus.level), 32'(r.end_level));
        check("end_game_over", 32'(bus.game_over), 32'(r.end_go));
        check("end_win", 32'(bus.win), 32'(r.end_win));
        $display("round lvl=%0d wrong_at=%0d -> phase=%0d level=%0d", r.lvl, r.wrong_at, bus.phase, bus.level);
    endtask

    initial begin
        int  ticks;
        int  n;
        bit  done;
        logic ft;

        tbl[0] = '{lvl: 1, wrong_at: -1, poke: 0, end_phase: 3'd1, end_level: 5'd1, end_go: 1'b0, end_win: 1'b0};
        tbl[1] = '{lvl: 2, wrong_at:  0, poke: 0, end_phase: 3'd6, end_level: 5'd2, end_go: 1'b1, end_win: 1'b0};
        tbl[2] = '{lvl: 1, wrong_at: -1, poke: 0, end_phase: 3'd1, end_level: 5'd1, end_go: 1'b0, end_win: 1'b0};
        tbl[3] = '{lvl: 2, wrong_at: -1, poke: 0, end_phase: 3'd1, end_level: 5'd2, end_go: 1'b0, end_win: 1'b0};
        tbl[4] = '{lvl: 3, wrong_at: -1, poke: 1, end_phase: 3'd7, end_level: 5'd3, end_go: 1'b0, end_win: 1'b1};

        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.btn_valid  = 1'b0;
        bus.btn_code   = 2'd0;

        // 1: reset state and idle
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        check("rst_phase", 32'(bus.phase), 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_lit_valid", 32'(bus.lit_valid), 32'd0);
        check("rst_lit_code", 32'(bus.lit_code), 32'd0);
        check("rst_game_over", 32'(bus.game_over), 32'd0);
        check("rst_win", 32'(bus.win), 32'd0);
        repeat (50) tick_clk();
        check("idle_phase", 32'(bus.phase), 32'd0);
        check("idle_lit_valid", 32'(bus.lit_valid), 32'd0);
        check("idle_level", 32'(bus.level), 32'd0);

        // 2: start latency and SHOW_ON duration
        bus.start = 1'b1;
        tick_clk();
        check("start_n1_phase", 32'(bus.phase), 32'd1);
        check("start_n1_lit", 32'(bus.lit_valid), 32'd0);
        tick_clk();
        check("start_n2_lit", 32'(bus.lit_valid), 32'd1);
        check("start_n2_phase", 32'(bus.phase), 32'd2);
        check("start_n2_level", 32'(bus.level), 32'd1);
        ticks = 0; n = 0; done = 0;
        while (!done && n < 40) begin
            ft = bus.frame_tick;
            tick_clk();
            n++;
            if (ft) ticks++;
            if (ticks == TICK_ON) begin
                check("show_on_drop", 32'(bus.lit_valid), 32'd0);
                check("show_off_phase", 32'(bus.phase), 32'd3);
                done = 1;
            end else if (bus.lit_valid !== 1'b1) begin
                check("show_on_early_drop", 32'(bus.lit_valid), 32'd1);
                done = 1;
            end
        end
        if (!done) check("show_on_timeout", 32'd0, 32'd1);

        // 3/4: correct round, then a wrong first press
        play_level(tbl[0]);
        play_level(tbl[1]);
        for (int k = 0; k < 3; k++) press(2'(k));
        check("lose_hold_phase", 32'(bus.phase), 32'd6);
        check("lose_hold_go", 32'(bus.game_over), 32'd1);
        bus.start = 1'b1;
        tick_clk();
        check("restart_phase", 32'(bus.phase), 32'd1);
        check("restart_go", 32'(bus.game_over), 32'd0);
        check("restart_level0", 32'(bus.level), 32'd0);
        tick_clk();
        check("restart_level1", 32'(bus.level), 32'd1);

        // 5: win path with ignored pokes during playback
        for (int t = 2; t < 5; t++) play_level(tbl[t]);
        for (int k = 0; k < 4; k++) press(2'(k));
        check("win_hold", 32'(bus.win), 32'd1);
        check("win_hold_phase", 32'(bus.phase), 32'd7);
        check("win_hold_lit", 32'(bus.lit_valid), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // 6: asynchronous reset mid SHOW_ON
        bus.start = 1'b1;
        tick_clk();
        wait_phase(3'd2, 10, "reach_show_on");
        check("pre_rst_lit", 32'(bus.lit_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_lit", 32'(bus.lit_valid), 32'd0);
        check("async_rst_level", 32'(bus.level), 32'd0);
        check("async_rst_phase", 32'(bus.phase), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        exp_q.delete();
        lvl_m = 0; prev_lit = 1'b0; prev_phase = 3'd0;

        // Input timeout (or its absence in the default build)
        bus.start = 1'b1;
        tick_clk();
        wait_phase(3'd4, 300, "to_reach_input");
`ifdef INPUT_TIMEOUT_EN
        ticks = 0; n = 0; done = 0;
        while (!done && n < 100) begin
            ft = bus.frame_tick;
            tick_clk();
            n++;
            if (ft) ticks++;
            if (ticks == TO_FR) begin
                check("timeout_lose", 32'(bus.phase), 32'd6);
                done = 1;
            end else if (bus.phase !== 3'd4) begin
                check("timeout_early", 32'(bus.phase), 32'd4);
                done = 1;
            end
        end
        if (!done) check("timeout_never", 32'd0, 32'd1);
`else
        repeat (40) tick_clk();
        check("no_timeout_phase", 32'(bus.phase), 32'd4);
        exp_q.push_back(mem_m[0]);
        press(mem_m[0]);
        check("late_press_echo", 32'(bus.phase), 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
Game-flow controller for the Simon VGA display. It generates a pseudo-random colour sequence, plays it back by telling the block renderer which quadrant to light, then collects player button presses and compares them against the stored sequence. It sits between the button debouncers and the block renderer. All timing is counted in display frames.

Parameters:
MAX_LEN, 16, maximum sequence length; reaching it in full means the player wins.
TICK_ON, 30, number of frame_tick pulses a quadrant stays lit during playback.
TICK_OFF, 10, number of frame_tick pulses of dark gap after each playback step; also the length of the echo of a player press.
LFSR_SEED, 16'hACE1, reset value of the LFSR; must be non-zero.
TIMEOUT_FRAMES, 300, input timeout in frames; used only when INPUT_TIMEOUT_EN is defined.

Ports:
clk  in  1  system clock
rst  in  1  reset
frame_tick  in  1  single-cycle pulse, once per frame (vsync)
start  in  1  single-cycle pulse that starts a new game
btn_valid  in  1  single-cycle pulse: a debounced button was pressed
btn_code  in  2  quadrant pressed: 0 red, 1 green, 2 blue, 3 yellow
lit_valid  out  1  renderer should highlight quadrant lit_code
lit_code  out  2  quadrant to highlight
phase  out  3  current state encoding, for the HUD/background colour
level  out  5  current sequence length, 0..MAX_LEN
game_over  out  1  held high after a wrong press
win  out  1  held high after MAX_LEN is completed

Interface: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset values: state IDLE, level 0, index 0, frame timer 0, LFSR = LFSR_SEED. All outputs are 0: lit_valid, lit_code, game_over, win; phase = IDLE code.
- The LFSR is a 16-bit Galois LFSR (taps 16,14,13,11). It advances every clk cycle, so user timing seeds the sequence.
- Outputs are Moore outputs decoded from registered state, index and memory. They are valid in the first cycle of the new state.
- Frame timer: increments only on frame_tick and is cleared on every state entry. A state with limit N exits in the cycle the N-th frame_tick is seen.
- IDLE: start -> EXTEND. level, game_over and win are cleared in the same cycle.
- EXTEND (1 cycle):
  - mem[level] <= lfsr[1:0]; level <= level+1; index <= 0; next state SHOW_ON.
  - Latency: start at cycle n gives lit_valid=1 at cycle n+2.
- SHOW_ON: lit_valid=1, lit_code=mem[index]. After TICK_ON ticks -> SHOW_OFF.
- SHOW_OFF: lit_valid=0. After TICK_OFF ticks:
  - if index==level-1: index <= 0, next state INPUT;
  - otherwise index+1, next state SHOW_ON.
- INPUT: lit_valid=0. On btn_valid:
  - btn_code==mem[index] -> ECHO;
  - otherwise -> LOSE.
- ECHO: lit_valid=1, lit_code=mem[index]. After TICK_OFF ticks:
  - index==level-1 and level==MAX_LEN -> WIN;
  - index==level-1 and level<MAX_LEN -> EXTEND;
  - otherwise index+1 -> INPUT.
- LOSE: game_over=1. start -> IDLE handling (restart). WIN: win=1; same restart rule.
- btn_valid is ignored in every state except INPUT, including presses during playback and during ECHO.
- start is ignored in EXTEND, SHOW_ON, SHOW_OFF, INPUT and ECHO.
- If btn_valid and frame_tick arrive in the same cycle in INPUT, the button wins and the timer clears on the state change.
- level never exceeds MAX_LEN. Sequence memory is MAX_LEN x 2 bits, written only in EXTEND and not reset.
- An asynchronous rst in any state aborts immediately; lit_valid drops in the same cycle.
- phase encoding: IDLE 0, EXTEND 1, SHOW_ON 2, SHOW_OFF 3, INPUT 4, ECHO 5, LOSE 6, WIN 7.

Optional Feature:
INPUT_TIMEOUT_EN
- Defined: the INPUT state runs the frame timer. TIMEOUT_FRAMES ticks without btn_valid -> LOSE. A button press in the same cycle as the final tick is evaluated normally and takes priority.
- Undefined: INPUT waits indefinitely and no timeout counter is synthesised.

Decomposition:
- Package simon_pkg: state enum with the phase codes above; quadrant codes RED/GREEN/BLUE/YELLOW = 0..3; matching 12-bit RGB constants for the renderer.
- Sub-module simon_lfsr: seed parameter, free-running, exposes a 16-bit state.
- FSM, timer and sequence memory stay in simon_sequencer.

Test Plan:
All scenarios use TICK_ON=2, TICK_OFF=1 and MAX_LEN=3, with frame_tick every 4 clk cycles.
1. Reset then idle for 50 cycles -> all outputs 0, phase=0, level=0.
2. Pulse start -> phase 1 at n+1; lit_valid=1 at n+2 with lit_code=mem[0]; lit_valid stays high exactly until the 2nd frame_tick, then drops; level=1.
3. Level 1: press the matching btn_code -> ECHO lights that code for 1 tick, then EXTEND; level=2; playback shows mem[0] then mem[1].
4. Level 2: press a wrong code as the first input -> phase=6 and game_over=1 next cycle; further btn_valid pulses have no effect; start restarts the game with level=1 and game_over=0.
5. Win path: three correct rounds -> phase=7, win=1, level=3. Pulses of btn_valid and start during SHOW_ON (before the win) have no effect.
6. Assert rst mid-SHOW_ON -> lit_valid=0 in the same cycle and level=0. With INPUT_TIMEOUT_EN and TIMEOUT_FRAMES=5: no press for 5 ticks in INPUT -> LOSE.
